fifo_wr_ctrl: RTL and testbench

- Write-side controller of the async FIFO, in the write clock domain, directly upstream of the dual-port FIFO memory.
- Turns write requests into the memory's write enable and write address.
- Maintains the binary and Gray write pointers and publishes the Gray pointer to the read-domain synchroniser.
- Generates full, almost-full, fill level and overflow status from the read pointer already synchronised into this domain.

---
 rtl/fifo_wr_ctrl.sv | 74 +++++++
 tb/tb_fifo_wr_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: memory write enable/address, binary and Gray
// write pointers, and full / almost-full / fill / overflow status from the synchronised rptr.
`timescale 1ns/1ps
module fifo_wr_ctrl #(
  parameter int unsigned addr_size = 3,
  parameter int unsigned af_level  = 6
) (
  input  logic                 w_clk,
  input  logic                 reset,
  input  logic                 w_inc,
  input  logic [addr_size:0]   wq2_rptr,
  output logic [addr_size-1:0] w_addr,
  output logic                 w_clk_en,
  output logic [addr_size:0]   w_ptr,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [addr_size:0]   w_fill,
  output logic                 w_overflow
);

  localparam int unsigned PtrW = addr_size + 1;

  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wgray_q, wgray_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [PtrW-1:0] rbin;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            overflow_q;

  // Gated by reset so the memory never sees a write while the pointers are held clear.
  assign w_clk_en = w_inc & ~full_q & reset;
  assign w_addr   = wbin_q[addr_size-1:0];

  always_comb begin
    rbin            = '0;
    rbin[addr_size] = wq2_rptr[addr_size];
    for (int i = int'(addr_size) - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end

    wbin_d  = wbin_q + PtrW'(w_clk_en);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    fill_d  = wbin_d - rbin;
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    full_d  = (wgray_d == {~wq2_rptr[addr_size -: 2], wq2_rptr[addr_size-2:0]});
    afull_d = (32'(fill_d) >= af_level);
  end

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      fill_q     <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      fill_q     <= fill_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      overflow_q <= w_inc & full_q;
    end
  end

  assign w_ptr         = wgray_q;
  assign w_full        = full_q;
  assign w_almost_full = afull_q;
  assign w_fill        = fill_q;
  assign w_overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: fill, overflow, release, async reset and pointer wrap.
`timescale 1ns/1ps
module tb_fifo_wr_ctrl;

  logic       w_clk = 1'b0;
  logic       reset;
  logic       w_inc;
  logic [3:0] wq2_rptr;
  logic [2:0] w_addr;
  logic       w_clk_en;
  logic [3:0] w_ptr;
  logic       w_full;
  logic       w_almost_full;
  logic [3:0] w_fill;
  logic       w_overflow;

  int errors = 0;
  int checks = 0;

  fifo_wr_ctrl #(
    .addr_size(3),
    .af_level (6)
  ) dut (
    .w_clk        (w_clk),
    .reset        (reset),
    .w_inc        (w_inc),
    .wq2_rptr     (wq2_rptr),
    .w_addr       (w_addr),
    .w_clk_en     (w_clk_en),
    .w_ptr        (w_ptr),
    .w_full       (w_full),
    .w_almost_full(w_almost_full),
    .w_fill       (w_fill),
    .w_overflow   (w_overflow)
  );

  always #5 w_clk = ~w_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the rising edge, away from it for both driving and sampling.
  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic check_clear(input string tag);
    check_eq({tag, ".addr"},  32'(w_addr), 32'd0);
    check_eq({tag, ".ptr"},   32'(w_ptr), 32'd0);
    check_eq({tag, ".fill"},  32'(w_fill), 32'd0);
    check_eq({tag, ".full"},  32'(w_full), 32'd0);
    check_eq({tag, ".afull"}, 32'(w_almost_full), 32'd0);
    check_eq({tag, ".ovf"},   32'(w_overflow), 32'd0);
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  logic [3:0] exp_ptr [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    w_inc    = 1'b1;
    wq2_rptr = 4'h0;
    #3;
    check_clear("rst_hold");
    check_eq("rst_hold.en", 32'(w_clk_en), 32'd0);
    w_inc = 1'b0;
    step();
    #2 reset = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      step();
      check_clear("idle");
    end

    // Eight writes with rptr at zero.
    for (int i = 0; i < 8; i++) begin
      w_inc = 1'b1;
      #1;
      check_eq("fill.addr", 32'(w_addr), 32'(i));
      check_eq("fill.en", 32'(w_clk_en), 32'd1);
      step();
      check_eq("fill.ptr", 32'(w_ptr), 32'(exp_ptr[i]));
      check_eq("fill.fill", 32'(w_fill), 32'(i + 1));
      check_eq("fill.afull", 32'(w_almost_full), 32'((i + 1) >= 6));
      check_eq("fill.full", 32'(w_full), 32'(i == 7));
    end

    // Ninth request while full is rejected.
    #1;
    check_eq("ovf.en", 32'(w_clk_en), 32'd0);
    check_eq("ovf.addr", 32'(w_addr), 32'd0);
    step();
    check_eq("ovf.pulse", 32'(w_overflow), 32'd1);
    check_eq("ovf.ptr", 32'(w_ptr), 32'hC);
    check_eq("ovf.full", 32'(w_full), 32'd1);
    check_eq("ovf.fillv", 32'(w_fill), 32'd8);
    w_inc = 1'b0;
    step();
    check_eq("ovf.end", 32'(w_overflow), 32'd0);

    // Read side frees one entry.
    wq2_rptr = 4'b0001;
    step();
    check_eq("free.full", 32'(w_full), 32'd0);
    check_eq("free.fill", 32'(w_fill), 32'd7);
    check_eq("free.afull", 32'(w_almost_full), 32'd1);
    w_inc = 1'b1;
    #1;
    check_eq("refill.en", 32'(w_clk_en), 32'd1);
    check_eq("refill.addr", 32'(w_addr), 32'd0);
    step();
    check_eq("refill.full", 32'(w_full), 32'd1);
    check_eq("refill.ptr", 32'(w_ptr), 32'hD);
    check_eq("refill.fill", 32'(w_fill), 32'd8);
    w_inc = 1'b0;

    // Asynchronous reset with wbin = 5.
    wq2_rptr = 4'h0;
    do_reset();
    w_inc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    w_inc = 1'b0;
    check_eq("pre_rst.ptr", 32'(w_ptr), 32'h7);
    #2 reset = 1'b0;
    #1;
    check_clear("async_rst");
    check_eq("async_rst.en", 32'(w_clk_en), 32'd0);
    #1 reset = 1'b1;
    step();
    w_inc = 1'b1;
    #1;
    check_eq("post_rst.addr", 32'(w_addr), 32'd0);
    check_eq("post_rst.en", 32'(w_clk_en), 32'd1);
    step();
    check_eq("post_rst.ptr", 32'(w_ptr), 32'h1);
    w_inc = 1'b0;

    // Wrap: rptr trails two entries behind for 20 writes.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      logic [3:0] wb;
      wb       = 4'(k);
      wq2_rptr = (k >= 1) ? to_gray(wb - 4'd1) : 4'h0;
      w_inc    = 1'b1;
      step();
      check_eq("wrap.full", 32'(w_full), 32'd0);
      check_eq("wrap.fill", 32'(w_fill), (k == 0) ? 32'd1 : 32'd2);
      check_eq("wrap.ptr", 32'(w_ptr), 32'(to_gray(wb + 4'd1)));
      if (k == 7)  check_eq("wrap.msb8", 32'(w_ptr[3]), 32'd1);
      if (k == 15) check_eq("wrap.msb16", 32'(w_ptr[3]), 32'd0);
    end
    w_inc = 1'b0;
    check_eq("wrap.afull", 32'(w_almost_full), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
